// File: rtl/dshift_seq.sv
// dshift_seq: command-driven sequencer for a bank of delay-shift lanes.
// Accepts one shift command (op/len/base/lk0), streams source reads, drives
// per-lane dir/lk0/din_sel, flushes the lanes and pulses done at the end.
// Optional feature macro: DSHIFT_SEQ_SKEW_EN. When it is defined, lane k is
// delayed k cycles for systolic injection. When it is undefined, all lanes
// share the lane-0 drive and DRAIN lasts one cycle.
module dshift_seq #(
    parameter int DEPTH  = 4,
    parameter int N_LANE = 4,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 10
) (
    input  logic                  clk,
    input  logic                  sys_rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic                  cmd_lk0,
    input  logic [LEN_W-1:0]      cmd_len,
    input  logic [ADDR_W-1:0]     cmd_base,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [2*N_LANE-1:0]   dir_o,
    output logic [N_LANE-1:0]     lk0_o,
    output logic [N_LANE-1:0]     din_sel_o,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        FLUSH  = 2'd2,
        DRAIN  = 2'd3
    } state_e;

    localparam logic [1:0] OP_CLR = 2'b00;
    localparam logic [1:0] OP_NEW = 2'b11;

`ifdef DSHIFT_SEQ_SKEW_EN
    localparam int N_EFF = N_LANE;
`else
    localparam int N_EFF = 1;
`endif

    localparam int FLUSH_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DRAIN_W = (N_EFF > 1) ? $clog2(N_EFF) : 1;
    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(DEPTH - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(N_EFF - 1);

    state_e               state_q, state_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [FLUSH_W-1:0]   flush_q, flush_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [1:0]           op_q, op_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic                 lk0_q, lk0_d;
    logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                 rd_en_q;
    logic                 busy_q;
    logic                 done_q, done_d;
    logic                 accept;

    // Lane-0 drive for the next cycle, derived from the current state so
    // that lane 0 sees the data one cycle after its read strobe.
    logic [1:0]           ln_dir_d;
    logic                 ln_lk0_d;
    logic                 ln_sel_d;

    // A command is only taken in IDLE and never while reset is asserted.
    assign cmd_ready = sys_rst && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    // Next-state, counters and command latch selection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        flush_d   = flush_q;
        drain_d   = drain_q;
        op_d      = op_q;
        len_d     = len_q;
        lk0_d     = lk0_q;
        rd_addr_d = rd_addr_q;
        done_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d  = cmd_op;
                    len_d = cmd_len;
                    lk0_d = cmd_lk0;
                    // Nothing to stream: complete at once and stay idle.
                    if ((cmd_op == OP_CLR) || (cmd_len == '0)) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = STREAM;
                        cnt_d     = '0;
                        rd_addr_d = cmd_base;
                    end
                end
            end
            STREAM: begin
                if (cnt_q == len_q - LEN_W'(1)) begin
                    if (op_q == OP_NEW) begin
                        state_d = DRAIN;
                        drain_d = '0;
                    end else begin
                        state_d = FLUSH;
                        flush_d = '0;
                    end
                end else begin
                    cnt_d     = cnt_q + LEN_W'(1);
                    rd_addr_d = rd_addr_q + ADDR_W'(1);
                end
            end
            FLUSH: begin
                if (flush_q == FLUSH_LAST) begin
                    state_d = DRAIN;
                    drain_d = '0;
                end else begin
                    flush_d = flush_q + FLUSH_W'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Lane-0 drive: streaming feeds source data, flushing pushes zeros with
    // the same direction, everything else clears the lanes.
    always_comb begin
        ln_dir_d = 2'b00;
        ln_lk0_d = 1'b0;
        ln_sel_d = 1'b0;
        if (state_q == STREAM) begin
            ln_dir_d = op_q;
            ln_sel_d = 1'b1;
            ln_lk0_d = (op_q == OP_NEW) ? lk0_q : 1'b0;
        end else if (state_q == FLUSH) begin
            ln_dir_d = op_q;
        end
    end

    // Control state and registered handshake/read outputs.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            flush_q   <= '0;
            drain_q   <= '0;
            rd_addr_q <= '0;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            flush_q   <= flush_d;
            drain_q   <= drain_d;
            rd_addr_q <= rd_addr_d;
            rd_en_q   <= (state_d == STREAM);
            busy_q    <= (state_d != IDLE);
            done_q    <= done_d;
        end
    end

    // Latched command fields; only meaningful while a command is active.
    always_ff @(posedge clk) begin
        op_q  <= op_d;
        len_q <= len_d;
        lk0_q <= lk0_d;
    end

    assign rd_en   = rd_en_q;
    assign rd_addr = rd_addr_q;
    assign busy    = busy_q;
    assign done    = done_q;

`ifdef DSHIFT_SEQ_SKEW_EN
    logic [1:0] dir_q [N_LANE];
    logic       lkl_q [N_LANE];
    logic       sel_q [N_LANE];

    // Skew chain: lane k repeats lane k-1 one cycle later.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            for (int k = 0; k < N_LANE; k++) begin
                dir_q[k] <= 2'b00;
                lkl_q[k] <= 1'b0;
                sel_q[k] <= 1'b0;
            end
        end else begin
            dir_q[0] <= ln_dir_d;
            lkl_q[0] <= ln_lk0_d;
            sel_q[0] <= ln_sel_d;
            for (int k = 1; k < N_LANE; k++) begin
                dir_q[k] <= dir_q[k-1];
                lkl_q[k] <= lkl_q[k-1];
                sel_q[k] <= sel_q[k-1];
            end
        end
    end

    for (genvar k = 0; k < N_LANE; k++) begin : g_lane
        assign dir_o[2*k +: 2] = dir_q[k];
        assign lk0_o[k]        = lkl_q[k];
        assign din_sel_o[k]    = sel_q[k];
    end
`else
    logic [1:0] dir_q;
    logic       lkl_q;
    logic       sel_q;

    // Single lane-0 register broadcast to every lane.
    always_ff @(posedge clk) begin
        if (!sys_rst) begin
            dir_q <= 2'b00;
            lkl_q <= 1'b0;
            sel_q <= 1'b0;
        end else begin
            dir_q <= ln_dir_d;
            lkl_q <= ln_lk0_d;
            sel_q <= ln_sel_d;
        end
    end

    assign dir_o     = {N_LANE{dir_q}};
    assign lk0_o     = {N_LANE{lkl_q}};
    assign din_sel_o = {N_LANE{sel_q}};
`endif

endmodule

// File: tb/tb_dshift_seq.sv
// Self-checking bench for dshift_seq: directed commands with expected
// per-cycle outputs derived from the command timing formulas, plus
// hand-computed address, lane and completion-cycle checks.
module tb_dshift_seq;

    localparam int DEPTH  = 4;
    localparam int N_LANE = 4;
    localparam int LEN_W  = 8;
    localparam int ADDR_W = 10;

`ifdef DSHIFT_SEQ_SKEW_EN
    localparam int SK = 1;
`else
    localparam int SK = 0;
`endif
    localparam int NE = (SK != 0) ? N_LANE : 1;

    logic                clk = 1'b0;
    logic                sys_rst;
    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic                cmd_lk0;
    logic [LEN_W-1:0]    cmd_len;
    logic [ADDR_W-1:0]   cmd_base;
    logic                rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [2*N_LANE-1:0] dir_o;
    logic [N_LANE-1:0]   lk0_o;
    logic [N_LANE-1:0]   din_sel_o;
    logic                busy;
    logic                done;

    dshift_seq #(
        .DEPTH (DEPTH),
        .N_LANE(N_LANE),
        .LEN_W (LEN_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .sys_rst  (sys_rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_lk0  (cmd_lk0),
        .cmd_len  (cmd_len),
        .cmd_base (cmd_base),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .dir_o    (dir_o),
        .lk0_o    (lk0_o),
        .din_sel_o(din_sel_o),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [9:0] addr_log [0:63];
    logic [1:0] dir3_log [0:63];
    int         done_at;
    int         waited;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic int dcycle(input logic [1:0] op, input int len);
        if (op == 2'b00 || len == 0) return 1;
        return len + ((op == 2'b11) ? 0 : DEPTH) + NE + 1;
    endfunction

    // Observed output bundle; rd_addr is masked while no read is issued.
    function automatic logic [29:0] obs_vec(input bit mask_addr);
        logic [9:0] a;
        a = (mask_addr && !rd_en) ? 10'd0 : rd_addr;
        return {rd_en, a, dir_o, lk0_o, din_sel_o, busy, done, cmd_ready};
    endfunction

    // Expected outputs at cycle T+j for a command accepted at edge T.
    function automatic logic [29:0] exp_vec(input logic [1:0] op, input int len,
                                            input logic [9:0] base, input logic lk0,
                                            input int j);
        logic       ren;
        logic [9:0] addr;
        logic [7:0] dir;
        logic [3:0] lk;
        logic [3:0] sel;
        int         d;
        int         s;
        bit         act;
        d    = dcycle(op, len);
        act  = (op != 2'b00) && (len > 0);
        ren  = act && (j >= 1) && (j <= len);
        addr = ren ? (base + 10'(j - 1)) : 10'd0;
        dir  = '0;
        lk   = '0;
        sel  = '0;
        for (int k = 0; k < 4; k++) begin
            s = k * SK;
            if (act && j >= 2 + s && j <= len + 1 + s) begin
                dir[2*k +: 2] = op;
                sel[k]        = 1'b1;
                lk[k]         = (op == 2'b11) ? lk0 : 1'b0;
            end else if (act && op != 2'b11 && j >= len + 2 + s && j <= len + DEPTH + 1 + s) begin
                dir[2*k +: 2] = op;
            end
        end
        return {ren, addr, dir, lk, sel, (j < d), (j == d), (j >= d)};
    endfunction

    // Offer a command and wait (bounded) for the handshake edge; returns
    // at the cycle right after acceptance.
    task automatic send_cmd(input logic [1:0] op, input int len, input logic [9:0] base,
                            input logic lk0, output int w);
        cmd_op    = op;
        cmd_len   = LEN_W'(len);
        cmd_base  = base;
        cmd_lk0   = lk0;
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        if (!cmd_ready) chk("accept_timeout", 64'(cmd_ready), 64'd1);
        tick();
        cmd_valid = 1'b0;
    endtask

    // Compare every cycle from T+1 to the done cycle; ends at the done cycle.
    task automatic check_cmd(input string tag, input logic [1:0] op, input int len,
                             input logic [9:0] base, input logic lk0);
        int d;
        d = dcycle(op, len);
        done_at = -1;
        for (int j = 1; j <= d; j++) begin
            chk($sformatf("%s_c%0d", tag, j), 64'(obs_vec(1'b1)), 64'(exp_vec(op, len, base, lk0, j)));
            if (j < 64) begin
                addr_log[j] = rd_addr;
                dir3_log[j] = dir_o[7:6];
            end
            if (done && done_at < 0) done_at = j;
            if (j < d) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        sys_rst   = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 2'b01;
        cmd_lk0   = 1'b0;
        cmd_len   = 8'd3;
        cmd_base  = 10'h0;

        // Reset held with a command offered: nothing accepted, all outputs 0.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_hold%0d", i), 64'(obs_vec(1'b0)), 64'd0);
        end
        cmd_valid = 1'b0;
        sys_rst   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("rst_rel%0d", i), 64'(obs_vec(1'b0)), 64'd1);
        end

        // POS, L=5, base 0x010.
        send_cmd(2'b01, 5, 10'h010, 1'b1, waited);
        check_cmd("pos", 2'b01, 5, 10'h010, 1'b1);
        chk("pos_addr1", 64'(addr_log[1]), 64'h010);
        chk("pos_addr5", 64'(addr_log[5]), 64'h014);
        chk("pos_done", 64'(done_at), (SK != 0) ? 64'd14 : 64'd11);
        chk("pos_l3_c4", 64'(dir3_log[4]), (SK != 0) ? 64'd0 : 64'd1);
        chk("pos_l3_c5", 64'(dir3_log[5]), 64'd1);
        chk("pos_l3_last", 64'(dir3_log[(SK != 0) ? 13 : 10]), 64'd1);

        // NEW with lk0=1 then lk0=0.
        send_cmd(2'b11, 2, 10'h100, 1'b1, waited);
        check_cmd("new1", 2'b11, 2, 10'h100, 1'b1);
        chk("new1_done", 64'(done_at), (SK != 0) ? 64'd7 : 64'd4);
        send_cmd(2'b11, 2, 10'h100, 1'b0, waited);
        check_cmd("new0", 2'b11, 2, 10'h100, 1'b0);

        // Address wrap.
        send_cmd(2'b10, 4, 10'h3FE, 1'b0, waited);
        check_cmd("wrap", 2'b10, 4, 10'h3FE, 1'b0);
        chk("wrap_a1", 64'(addr_log[1]), 64'h3FE);
        chk("wrap_a2", 64'(addr_log[2]), 64'h3FF);
        chk("wrap_a3", 64'(addr_log[3]), 64'h000);
        chk("wrap_a4", 64'(addr_log[4]), 64'h001);

        // Zero length and CLR complete in one cycle with no reads.
        send_cmd(2'b01, 0, 10'h055, 1'b0, waited);
        check_cmd("len0", 2'b01, 0, 10'h055, 1'b0);
        chk("len0_done", 64'(done_at), 64'd1);
        send_cmd(2'b00, 7, 10'h077, 1'b1, waited);
        check_cmd("clr", 2'b00, 7, 10'h077, 1'b1);
        chk("clr_done", 64'(done_at), 64'd1);

        // Back-to-back: second command held valid through the first.
        send_cmd(2'b11, 1, 10'h020, 1'b1, waited);
        cmd_op    = 2'b01;
        cmd_len   = 8'd2;
        cmd_base  = 10'h040;
        cmd_lk0   = 1'b0;
        cmd_valid = 1'b1;
        check_cmd("b2bA", 2'b11, 1, 10'h020, 1'b1);
        send_cmd(2'b01, 2, 10'h040, 1'b0, waited);
        chk("b2b_wait", 64'(waited), 64'd0);
        check_cmd("b2bB", 2'b01, 2, 10'h040, 1'b0);

        // NEG, L=3: completion cycle depends on lane skew.
        send_cmd(2'b10, 3, 10'h005, 1'b0, waited);
        check_cmd("neg", 2'b10, 3, 10'h005, 1'b0);
        chk("neg_done", 64'(done_at), (SK != 0) ? 64'd12 : 64'd9);

        // Reset during FLUSH abandons the command without done.
        send_cmd(2'b01, 2, 10'h200, 1'b0, waited);
        for (int i = 0; i < 3; i++) tick();
        chk("mid_dir0", 64'(dir_o[1:0]), 64'd1);
        sys_rst = 1'b0;
        tick();
        chk("mid_rst", 64'(obs_vec(1'b0)), 64'd0);
        sys_rst = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk($sformatf("mid_after%0d", i), 64'(obs_vec(1'b0)), 64'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dshift_seq.md
# dshift_seq

Command-driven sequencer for a bank of `N_LANE` delay-shift lanes feeding the systolic array. It accepts one shift command at a time (op, length, source base address, `l_k_0`) over a valid/ready handshake. It then issues source-buffer reads and drives each lane's `dir`/`l_k_0`/`din` select, skewing lane *k* by *k* cycles for systolic injection. It flushes the lanes and pulses `done` once the last lane has finished.

## Interface
- `DEPTH`, 4: stages per lane; sets flush length.
- `N_LANE`, 4: number of lanes driven.
- `LEN_W`, 8: width of the element count.
- `ADDR_W`, 10: source buffer address width.

- `clk` input 1: the single clock.
- `sys_rst` input 1: reset, synchronous, active-low.
- `cmd_valid` input 1: command offered.
- `cmd_ready` output 1: command accepted when both high at a clk edge.
- `cmd_op` input 2: 00 CLR, 01 POS, 10 NEG, 11 NEW.
- `cmd_lk0` input 1: `l_k_0` value for NEW.
- `cmd_len` input LEN_W: number of elements to stream.
- `cmd_base` input ADDR_W: first source address.
- `rd_en` output 1: source buffer read strobe. Data is returned 1 cycle later.
- `rd_addr` output ADDR_W: source read address.
- `dir_o` output 2*N_LANE: lane *k* direction is bits [2k+1:2k].
- `lk0_o` output N_LANE: per-lane `l_k_0`.
- `din_sel_o` output N_LANE: 1 = lane takes source data, 0 = lane takes zero.
- `busy` output 1: command in progress.
- `done` output 1: one-cycle completion pulse.

## Operation
- States: IDLE, STREAM, FLUSH, DRAIN.
- IDLE:
  - `cmd_ready` = `sys_rst`.
  - Lane-0 drive is `dir`=00 (clears the lanes), `din_sel`=0.
- Accept at edge T:
  - Latch op, len, base, lk0.
  - CLR or `cmd_len`=0: no reads, no lane activity, `done` at T+1, remain IDLE.
- STREAM, `cnt` 0..len-1:
  - `rd_en`=1, `rd_addr` = base+cnt modulo 2^ADDR_W (wraps silently).
  - Lane-0 `dir`=op and `din_sel`=1 one cycle after each read.
  - Lane-0 `lk0` = latched lk0 for NEW, 0 otherwise.
- FLUSH (POS/NEG only):
  - DEPTH further cycles with lane-0 `dir`=op, `din_sel`=0, so data fully exits.
  - NEW skips FLUSH.
- DRAIN: waits until the delayed lane pipeline is empty, then returns to IDLE with `done`=1.
- Lane *k* (`dir`, `lk0`, `din_sel`) is the lane-0 drive delayed *k* cycles through a register chain. In IDLE the chain shifts in `dir`=00.
- `cnt` is LEN_W bits. The flush counter is sized to DEPTH and the drain counter to N_LANE.
- Reset mid-command: at the next edge with `sys_rst` low, all state returns to IDLE. The command is abandoned and no `done` is issued.

## Timing
- All outputs are registered except `cmd_ready`.
- Reset values:
  - `rd_en`=0, `rd_addr`=0, `dir_o`=0, `lk0_o`=0, `din_sel_o`=0, `busy`=0, `done`=0.
  - `cmd_ready`=0 while `sys_rst` low.
- For a command accepted at T with len L ≥ 1:
  - `rd_en` is high T+1..T+L.
  - Lane-0 active (`din_sel`=1) T+2..T+L+1.
  - POS/NEG lane-0 flush T+L+2..T+L+DEPTH+1.
  - Lane *k* is the same window shifted +k.
- `done` cycle D:
  - POS/NEG: D = T+L+DEPTH+N_LANE+1.
  - NEW: D = T+L+N_LANE+1.
- `busy` is high T+1..D-1.
- `cmd_ready` is high at D, so back-to-back acceptance at D is allowed. The next command's first `rd_en` is at D+1.
- `cmd_valid` during `busy` is held off (`cmd_ready`=0); the command is not dropped.

## Configuration
- `DSHIFT_SEQ_SKEW_EN`:
  - Defined: lane *k* is delayed *k* cycles as above.
  - Undefined: all lanes receive the lane-0 drive in the same cycle, the delay chain is removed, and DRAIN lasts 1 cycle. Every formula above then uses N_LANE=1.

## Test plan
- **Reset:** hold `sys_rst`=0 for 3 cycles with `cmd_valid`=1 -> `cmd_ready`=0, all outputs 0, no `done` after release until a new command is accepted.
- **POS, skewed:** L=5, base=0x010, accepted at T -> `rd_addr` 0x010..0x014 on T+1..T+5; lane 3 `dir`=01 at T+5..T+13; `done` at T+14 (DEPTH=4, N_LANE=4).
- **NEW:** lk0=1, L=2 -> lane-0 `dir`=11 and `lk0`=1 at T+2..T+3, no flush, `done` at T+7; repeat with lk0=0 -> `lk0_o`=0.
- **Wrap and zero-length:** base=0x3FE, L=4 -> `rd_addr` 0x3FE, 0x3FF, 0x000, 0x001. A separate command with L=0 or op=CLR -> no `rd_en`, `done` at T+1.
- **Back-to-back and mid-command reset:** second command held valid is accepted exactly at the first command's `done` cycle. Dropping `sys_rst` during FLUSH -> next cycle all outputs 0, no `done`.
- **Macro undefined:** NEG L=3 -> all lanes `dir`=10 together T+2..T+8, `done` at T+9.
